mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single memory unit between the memory traversal engine (port T) and the execute engine (port E). Each port sees a private copy of the memory-unit request/ready interface. The arbiter buffers one pending request per port, issues requests to the memory unit one at a time, and returns read data and a ready pulse only to the port that owns the in-flight access. It sits between both engines and the memory unit.

## Interface
Parameters:
- ADDR_W, default `memory_addr_width`: memory address width.
- DATA_W, default `memory_data_width`: memory word width, including tag bits.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- t_mem_execute  in  1  port T request strobe.
- t_mem_func  in  2  port T function (`GET_CONTENTS`, `SET_CONTENTS`, ...).
- t_address  in  ADDR_W  port T address.
- t_write_data  in  DATA_W  port T write word.
- t_mem_ready  out  1  port T completion pulse.
- t_read_data  out  DATA_W  port T read word.
- e_mem_execute, e_mem_func, e_address, e_write_data, e_mem_ready, e_read_data: port E, same directions and widths as port T.
- t_free_addr, e_free_addr  out  ADDR_W  combinational copies of free_addr.
- mem_execute  out  1  request strobe to the memory unit.
- mem_func  out  2  function to the memory unit.
- address  out  ADDR_W  address to the memory unit.
- write_data  out  DATA_W  write word to the memory unit.
- mem_ready  in  1  memory unit completion.
- read_data  in  DATA_W  memory unit read word.
- free_addr  in  ADDR_W  memory unit next free address.
- busy  out  1  high while an access is in flight.
- arb_error  out  2  sticky overflow flags: [1]=E, [0]=T.

## Operation
- Per-port slot: valid bit plus func, address and wdata.
- Port request capture: on a clock edge where x_mem_execute=1 and the slot is empty, the slot loads func/address/wdata and valid is set.
- Holding x_mem_execute high across several cycles counts as one request. A rising edge is detected per port with a registered copy of the strobe.
- Overflow: a new rising edge while that port's slot is valid sets arb_error[x]. The request is dropped and the slot keeps its original contents.
- FSM states:
  - IDLE: if any slot is valid, choose a winner, go to ISSUE.
  - ISSUE: drive mem_execute=1 for exactly one cycle with the winner's fields, go to WAIT.
  - WAIT: mem_execute=0, fields held stable. On mem_ready, capture read_data and go to DONE.
  - DONE: pulse x_mem_ready=1 for one cycle on the winner only, clear its slot valid, go to IDLE.
- Winner selection is defined under Configuration.
- x_read_data is registered and holds its last value until the next completion for that port.
- The non-owning port's x_mem_ready stays 0 at all times.
- busy=1 in ISSUE, WAIT and DONE.
- A port may capture a new request in the same edge its DONE clears the slot; the new request wins the slot.

## Timing
- Reset values: mem_execute=0, mem_func=0, address=0, write_data=0, t/e_mem_ready=0, t/e_read_data=0, busy=0, arb_error=0, both slots empty, FSM=IDLE.
- Reset mid-access: the in-flight operation is abandoned with no ready pulse. The memory unit shares rst.
- Request strobe rises at edge N: slot valid after N. If IDLE, ISSUE occupies cycle N+1 and mem_execute is high in N+1.
- mem_ready sampled high at edge M: x_mem_ready and x_read_data are valid in cycle M+1.
- Minimum round trip from strobe edge to ready is 3 cycles plus memory latency.
- mem_ready seen outside WAIT is ignored.
- arb_error clears only on reset.
- Back-to-back service: after DONE, IDLE evaluates the slots in the following cycle. There is one idle cycle between accesses.

## Configuration
- MEM_ARB_ROUND_RR_EN defined: round-robin arbitration.
  - A last-grant bit, reset to T, gives the port not served last priority when both slots are valid.
  - A single valid port always wins.
- Undefined: fixed priority, E before T.
  - T can starve only while E keeps its slot continuously valid.

## Test plan
- Single T read: t_mem_execute pulse with GET_CONTENTS at address 0x010, memory returns 0xABCD after 2 cycles -> one mem_execute pulse with address=0x010; t_mem_ready pulses once with t_read_data=0xABCD; e_mem_ready stays 0.
- Simultaneous T and E strobes, RR undefined -> E is served first, then T. RR defined after reset -> E is served first (last grant=T), then T. Each port sees exactly one ready pulse.
- Overflow: a second T strobe before T's DONE -> arb_error=2'b01, only one access issued for T, original address used.
- E write (SET_CONTENTS, 0x020, 0x5555) while a T read is in WAIT -> the E write is issued only after T's DONE. write_data=0x5555 during E's ISSUE.
- rst asserted during WAIT -> all outputs at reset values next cycle, no ready pulse. A fresh request after reset completes normally.
- T strobe held high for 4 cycles -> a single access and arb_error=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory unit between the traversal engine (port T)
// and the execute engine (port E). One pending request is buffered per port;
// accesses are issued one at a time and completions are routed back only to
// the port that owns the in-flight access.
// Optional feature: define MEM_ARB_ROUND_RR_EN for round-robin arbitration;
// otherwise E has fixed priority over T.

`ifndef MEMORY_ADDR_WIDTH
`define MEMORY_ADDR_WIDTH 16
`endif
`ifndef MEMORY_DATA_WIDTH
`define MEMORY_DATA_WIDTH 16
`endif

module mem_arbiter #(
  parameter int ADDR_W = `MEMORY_ADDR_WIDTH,
  parameter int DATA_W = `MEMORY_DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  // port T
  input  logic              t_mem_execute,
  input  logic [1:0]        t_mem_func,
  input  logic [ADDR_W-1:0] t_address,
  input  logic [DATA_W-1:0] t_write_data,
  output logic              t_mem_ready,
  output logic [DATA_W-1:0] t_read_data,
  // port E
  input  logic              e_mem_execute,
  input  logic [1:0]        e_mem_func,
  input  logic [ADDR_W-1:0] e_address,
  input  logic [DATA_W-1:0] e_write_data,
  output logic              e_mem_ready,
  output logic [DATA_W-1:0] e_read_data,
  output logic [ADDR_W-1:0] t_free_addr,
  output logic [ADDR_W-1:0] e_free_addr,
  // memory unit side
  output logic              mem_execute,
  output logic [1:0]        mem_func,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] read_data,
  input  logic [ADDR_W-1:0] free_addr,
  output logic              busy,
  output logic [1:0]        arb_error
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_t;

  state_t state;
  logic   owner;       // 0 = T, 1 = E
  logic   last_grant;  // 0 = T, 1 = E

  // Per-port request slots
  logic              t_exec_q, e_exec_q;
  logic              t_valid, e_valid;
  logic [1:0]        t_func, e_func;
  logic [ADDR_W-1:0] t_addr, e_addr;
  logic [DATA_W-1:0] t_wdata, e_wdata;

  logic t_rise, e_rise, t_clear, e_clear, t_cap, e_cap, t_ovf, e_ovf;
  logic t_avail, e_avail, pick_e;
  logic [1:0]        t_sel_func, e_sel_func;
  logic [ADDR_W-1:0] t_sel_addr, e_sel_addr;
  logic [DATA_W-1:0] t_sel_wdata, e_sel_wdata;

  // Request edge detection, capture/overflow decisions and winner selection
  always_comb begin
    t_rise  = t_mem_execute & ~t_exec_q;
    e_rise  = e_mem_execute & ~e_exec_q;
    // A slot being released this edge is free for a new capture
    t_clear = (state == StDone) & ~owner;
    e_clear = (state == StDone) & owner;
    t_cap   = t_rise & (~t_valid | t_clear);
    e_cap   = e_rise & (~e_valid | e_clear);
    t_ovf   = t_rise & t_valid & ~t_clear;
    e_ovf   = e_rise & e_valid & ~e_clear;
    // A request arriving this edge is eligible immediately
    t_avail = t_valid | t_cap;
    e_avail = e_valid | e_cap;
    t_sel_func  = t_valid ? t_func  : t_mem_func;
    t_sel_addr  = t_valid ? t_addr  : t_address;
    t_sel_wdata = t_valid ? t_wdata : t_write_data;
    e_sel_func  = e_valid ? e_func  : e_mem_func;
    e_sel_addr  = e_valid ? e_addr  : e_address;
    e_sel_wdata = e_valid ? e_wdata : e_write_data;
`ifdef MEM_ARB_ROUND_RR_EN
    // On contention the port not granted last time wins
    pick_e = e_avail & (~t_avail | ~last_grant);
`else
    pick_e = e_avail;
`endif
  end

  // Slot bookkeeping and sticky overflow flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_exec_q  <= 1'b0;
      e_exec_q  <= 1'b0;
      t_valid   <= 1'b0;
      e_valid   <= 1'b0;
      t_func    <= '0;
      e_func    <= '0;
      t_addr    <= '0;
      e_addr    <= '0;
      t_wdata   <= '0;
      e_wdata   <= '0;
      arb_error <= 2'b00;
    end else begin
      t_exec_q <= t_mem_execute;
      e_exec_q <= e_mem_execute;
      if (t_cap) begin
        t_valid <= 1'b1;
        t_func  <= t_mem_func;
        t_addr  <= t_address;
        t_wdata <= t_write_data;
      end else if (t_clear) begin
        t_valid <= 1'b0;
      end
      if (e_cap) begin
        e_valid <= 1'b1;
        e_func  <= e_mem_func;
        e_addr  <= e_address;
        e_wdata <= e_write_data;
      end else if (e_clear) begin
        e_valid <= 1'b0;
      end
      arb_error <= arb_error | {e_ovf, t_ovf};
    end
  end

  // Access sequencer: grant, issue one strobe, wait for memory, route completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StIdle;
      owner       <= 1'b0;
      last_grant  <= 1'b0;
      mem_execute <= 1'b0;
      mem_func    <= '0;
      address     <= '0;
      write_data  <= '0;
      t_mem_ready <= 1'b0;
      e_mem_ready <= 1'b0;
      t_read_data <= '0;
      e_read_data <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (t_avail | e_avail) begin
            owner       <= pick_e;
            last_grant  <= pick_e;
            mem_execute <= 1'b1;
            mem_func    <= pick_e ? e_sel_func  : t_sel_func;
            address     <= pick_e ? e_sel_addr  : t_sel_addr;
            write_data  <= pick_e ? e_sel_wdata : t_sel_wdata;
            state       <= StIssue;
          end
        end
        StIssue: begin
          mem_execute <= 1'b0;
          state       <= StWait;
        end
        StWait: begin
          if (mem_ready) begin
            if (owner) begin
              e_read_data <= read_data;
              e_mem_ready <= 1'b1;
            end else begin
              t_read_data <= read_data;
              t_mem_ready <= 1'b1;
            end
            state <= StDone;
          end
        end
        StDone: begin
          t_mem_ready <= 1'b0;
          e_mem_ready <= 1'b0;
          state       <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign busy        = (state != StIdle);
  assign t_free_addr = free_addr;
  assign e_free_addr = free_addr;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios followed by random traffic, all checked
// against a transaction-level model of the arbiter and a small memory model.

module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam logic [1:0] GET = 2'd0;
  localparam logic [1:0] SET = 2'd1;

  logic          clk = 1'b0;
  logic          rst;
  logic          t_mem_execute, e_mem_execute;
  logic [1:0]    t_mem_func, e_mem_func;
  logic [AW-1:0] t_address, e_address;
  logic [DW-1:0] t_write_data, e_write_data;
  logic          t_mem_ready, e_mem_ready;
  logic [DW-1:0] t_read_data, e_read_data;
  logic [AW-1:0] t_free_addr, e_free_addr;
  logic          mem_execute;
  logic [1:0]    mem_func;
  logic [AW-1:0] address;
  logic [DW-1:0] write_data;
  logic          mem_ready;
  logic [DW-1:0] read_data;
  logic [AW-1:0] free_addr;
  logic          busy;
  logic [1:0]    arb_error;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .t_mem_execute(t_mem_execute), .t_mem_func(t_mem_func), .t_address(t_address),
    .t_write_data(t_write_data), .t_mem_ready(t_mem_ready), .t_read_data(t_read_data),
    .e_mem_execute(e_mem_execute), .e_mem_func(e_mem_func), .e_address(e_address),
    .e_write_data(e_write_data), .e_mem_ready(e_mem_ready), .e_read_data(e_read_data),
    .t_free_addr(t_free_addr), .e_free_addr(e_free_addr),
    .mem_execute(mem_execute), .mem_func(mem_func), .address(address),
    .write_data(write_data), .mem_ready(mem_ready), .read_data(read_data),
    .free_addr(free_addr), .busy(busy), .arb_error(arb_error)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Transaction-level model; index 0 = T, 1 = E
  bit            m_valid[2];
  logic [1:0]    m_func[2];
  logic [AW-1:0] m_addr[2];
  logic [DW-1:0] m_wd[2];
  bit            m_prev[2];
  bit            m_done[2];
  logic [DW-1:0] m_rd[2];
  logic [1:0]    m_err;
  bit            inflight;
  int            owner;
  bit            last_e;
  int            issues[2];
  int            readies[2];

  // Memory model
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] rsp_data;
  int            rsp_cnt;
  int            lat_min, lat_max;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int p = 0; p < 2; p++) begin
      m_valid[p] = 0; m_prev[p] = 0; m_done[p] = 0; m_rd[p] = '0;
      issues[p] = 0; readies[p] = 0;
    end
    m_err = 2'b00; inflight = 0; owner = 0; last_e = 0; rsp_cnt = 0;
  endtask

  task automatic drive(input int p, input bit on, input logic [1:0] f,
                       input logic [AW-1:0] a, input logic [DW-1:0] w);
    if (p == 0) begin
      t_mem_execute = on; t_mem_func = f; t_address = a; t_write_data = w;
    end else begin
      e_mem_execute = on; e_mem_func = f; e_address = a; e_write_data = w;
    end
  endtask

  // One clock: advance the model by the rules of the arbiter, then compare
  task automatic tick();
    bit            strobe[2];
    logic [1:0]    f[2];
    logic [AW-1:0] a[2];
    logic [DW-1:0] w[2];
    logic          mr_edge;
    logic [DW-1:0] rd_edge;
    bit            exp_rdy[2];
    int            win;
    strobe[0] = t_mem_execute; f[0] = t_mem_func; a[0] = t_address; w[0] = t_write_data;
    strobe[1] = e_mem_execute; f[1] = e_mem_func; a[1] = e_address; w[1] = e_write_data;
    mr_edge = mem_ready;
    rd_edge = read_data;
    @(posedge clk); #1;
    for (int p = 0; p < 2; p++) begin
      if (m_done[p]) begin m_valid[p] = 0; m_done[p] = 0; end
      if (strobe[p] && !m_prev[p]) begin
        if (m_valid[p]) m_err[p] = 1'b1;
        else begin
          m_valid[p] = 1; m_func[p] = f[p]; m_addr[p] = a[p]; m_wd[p] = w[p];
        end
      end
      m_prev[p] = strobe[p];
    end
    exp_rdy[0] = 0; exp_rdy[1] = 0;
    if (inflight && mr_edge) begin
      exp_rdy[owner] = 1; m_rd[owner] = rd_edge; inflight = 0; m_done[owner] = 1;
      readies[owner]++;
    end
    chk("t_mem_ready", t_mem_ready, exp_rdy[0]);
    chk("e_mem_ready", e_mem_ready, exp_rdy[1]);
    chk("t_read_data", t_read_data, m_rd[0]);
    chk("e_read_data", e_read_data, m_rd[1]);
    chk("arb_error", arb_error, m_err);
    chk("t_free_addr", t_free_addr, free_addr);
    chk("e_free_addr", e_free_addr, free_addr);
    // Memory responder output for the coming cycle
    mem_ready = 1'b0;
    read_data = DW'($urandom);
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin mem_ready = 1'b1; read_data = rsp_data; end
    end
    if (mem_execute) begin
      chk("issue_while_inflight", inflight, 0);
      if (m_valid[0] && m_valid[1]) begin
`ifdef MEM_ARB_ROUND_RR_EN
        win = last_e ? 0 : 1;
`else
        win = 1;
`endif
      end else if (m_valid[1]) win = 1;
      else if (m_valid[0]) win = 0;
      else win = -1;
      chk("issue_has_request", win >= 0, 1);
      if (win >= 0) begin
        chk("mem_func", mem_func, m_func[win]);
        chk("address", address, m_addr[win]);
        chk("write_data", write_data, m_wd[win]);
        chk("busy_issue", busy, 1);
        inflight = 1; owner = win; last_e = (win == 1); issues[win]++;
        if (m_func[win] == SET) begin
          mem[m_addr[win][7:0]] = m_wd[win];
          rsp_data = ~m_wd[win];
        end else rsp_data = mem[m_addr[win][7:0]];
        rsp_cnt = $urandom_range(lat_max, lat_min);
      end
    end
    free_addr = AW'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 2'd0, '0, '0);
    drive(1, 0, 2'd0, '0, '0);
    mem_ready = 1'b0; read_data = '0;
    model_clear();
    #1;
    chk("async_busy", busy, 0);
    chk("async_ready", {t_mem_ready, e_mem_ready}, 0);
    @(posedge clk); #1; @(posedge clk); #1;
    chk("rst_mem_execute", mem_execute, 0);
    chk("rst_mem_func", mem_func, 0);
    chk("rst_address", address, 0);
    chk("rst_write_data", write_data, 0);
    chk("rst_ready", {t_mem_ready, e_mem_ready}, 0);
    chk("rst_read_data", {t_read_data, e_read_data}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_arb_error", arb_error, 0);
    rst = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    drive(0, 0, 2'd0, '0, '0);
    drive(1, 0, 2'd0, '0, '0);
    while ((m_valid[0] || m_valid[1] || inflight || m_done[0] || m_done[1]) && k < 80) begin
      tick();
      k++;
    end
    chk("drain_timeout", k < 80, 1);
    chk("busy_after_drain", busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
    free_addr = '0;
    lat_min = 2; lat_max = 2;
    do_reset();

    // Single T read at 0x010 returning 0xABCD after 2 cycles
    mem[8'h10] = 16'hABCD;
    drive(0, 1, GET, 16'h0010, '0);
    tick();
    chk("t_issue_next_cycle", mem_execute, 1);
    chk("t_issue_addr", address, 16'h0010);
    drain();
    chk("t_single_rdata", t_read_data, 16'hABCD);
    chk("t_single_readies", readies[0], 1);
    chk("t_single_e_readies", readies[1], 0);

    // Simultaneous strobes: E first in both arbitration modes after reset
    do_reset();
    drive(0, 1, GET, 16'h0044, '0);
    drive(1, 1, GET, 16'h0055, '0);
    tick();
    chk("simul_first_addr", address, 16'h0055);
    drain();
    chk("simul_readies", {readies[1][7:0], readies[0][7:0]}, 16'h0101);

    // Overflow: second T strobe before DONE is dropped
    do_reset();
    lat_min = 3; lat_max = 3;
    drive(0, 1, GET, 16'h0030, '0);
    tick();
    drive(0, 0, GET, 16'h0030, '0);
    tick();
    drive(0, 1, GET, 16'h0040, '0);
    tick();
    drain();
    chk("ovf_flag", arb_error, 2'b01);
    chk("ovf_issues", issues[0], 1);

    // E write arriving while a T read is in WAIT
    do_reset();
    drive(0, 1, GET, 16'h0011, '0);
    tick();
    drive(0, 0, GET, 16'h0011, '0);
    tick();
    drive(1, 1, SET, 16'h0020, 16'h5555);
    tick();
    chk("e_not_issued_during_t", mem_execute, 0);
    drain();
    chk("e_write_issues", issues[1], 1);
    chk("e_write_mem", mem[8'h20], 16'h5555);
    chk("e_write_rdata", e_read_data, 16'hAAAA);

    // Reset during WAIT, then a fresh request
    do_reset();
    drive(0, 1, GET, 16'h0012, '0);
    tick();
    drive(0, 0, GET, 16'h0012, '0);
    tick();
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    drive(0, 1, GET, 16'h0013, '0);
    tick();
    drain();
    chk("post_reset_readies", readies[0], 1);
    chk("post_reset_rdata", t_read_data, mem[8'h13]);

    // Strobe held for 4 cycles counts once
    do_reset();
    lat_min = 1; lat_max = 1;
    drive(0, 1, GET, 16'h0014, '0);
    for (int i = 0; i < 4; i++) tick();
    drain();
    chk("held_issues", issues[0], 1);
    chk("held_error", arb_error, 0);

    // Memory ready outside WAIT is ignored
    mem_ready = 1'b1;
    tick();
    chk("spurious_ready", {t_mem_ready, e_mem_ready}, 0);
    chk("spurious_busy", busy, 0);

    // Random traffic
    for (int r = 0; r < 3; r++) begin
      do_reset();
      lat_min = 1; lat_max = 4;
      for (int c = 0; c < 300; c++) begin
        drive(0, ($urandom_range(0, 4) == 0), 2'($urandom), 16'($urandom_range(0, 255)),
              DW'($urandom));
        drive(1, ($urandom_range(0, 5) == 0), 2'($urandom), 16'($urandom_range(0, 255)),
              DW'($urandom));
        tick();
      end
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
